// File: rtl/noc_link_rx_buffer.sv
`default_nettype none
// =============================================================================
// Module   : noc_link_rx_buffer
// Purpose  : Receive end of a credit-based router link. Buffers incoming flits,
//            returns one credit per dequeued flit and presents the head flit as
//            an AXI-Stream style stream. Optional statistics: NOC_LINK_RX_STATS_EN.
// Revision : 1.0  initial release
// =============================================================================
module noc_link_rx_buffer #(
    parameter int FLIT_WIDTH        = 64,
    parameter int TID_WIDTH         = 2,
    parameter int TDEST_WIDTH       = 4,
    parameter int DEST_WIDTH        = TDEST_WIDTH + TID_WIDTH,
    parameter int FLIT_BUFFER_DEPTH = 2
) (
    input  logic                                     clk_noc,
    input  logic                                     rst_n,
    input  logic [FLIT_WIDTH-1:0]                    data_in,
    input  logic [DEST_WIDTH-1:0]                    dest_in,
    input  logic                                     is_tail_in,
    input  logic                                     send_in,
    output logic                                     credit_out,
    output logic                                     m_tvalid,
    input  logic                                     m_tready,
    output logic [FLIT_WIDTH-1:0]                    m_tdata,
    output logic                                     m_tlast,
    output logic [TID_WIDTH-1:0]                     m_tid,
    output logic [TDEST_WIDTH-1:0]                   m_tdest,
    output logic [$clog2(FLIT_BUFFER_DEPTH+1)-1:0]   occupancy,
`ifdef NOC_LINK_RX_STATS_EN
    output logic [31:0]                              pkt_count,
    output logic [31:0]                              flit_count,
    output logic [$clog2(FLIT_BUFFER_DEPTH+1)-1:0]   peak_occupancy,
`endif
    output logic                                     err_overflow,
    output logic                                     err_dest_change
);

    localparam int c_PTR_W = (FLIT_BUFFER_DEPTH > 1) ? $clog2(FLIT_BUFFER_DEPTH) : 1;
    localparam int c_OCC_W = $clog2(FLIT_BUFFER_DEPTH + 1);
    localparam int c_ENT_W = FLIT_WIDTH + DEST_WIDTH + 1;
    localparam logic [c_PTR_W-1:0] c_PTR_LAST = c_PTR_W'(FLIT_BUFFER_DEPTH - 1);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE  = c_PTR_W'(1);
    localparam logic [c_OCC_W-1:0] c_OCC_FULL = c_OCC_W'(FLIT_BUFFER_DEPTH);
    localparam logic [c_OCC_W-1:0] c_OCC_ONE  = c_OCC_W'(1);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        IN_PKT = 1'b1
    } pkt_state_t;

    logic [c_ENT_W-1:0]    mem_q [FLIT_BUFFER_DEPTH];
    logic [c_PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [c_PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [c_OCC_W-1:0]    occ_q, occ_d;
    logic                  credit_q, credit_d;
    logic                  err_ovf_q, err_ovf_d;
    logic                  err_dest_q, err_dest_d;
    pkt_state_t            state_q, state_d;
    logic [DEST_WIDTH-1:0] dest_lat_q, dest_lat_d;

    logic                  w_full;
    logic                  w_pop;
    logic                  w_push;
    logic [c_ENT_W-1:0]    w_head;

    assign w_full   = (occ_q == c_OCC_FULL);
    assign m_tvalid = (occ_q != '0);
    assign w_pop    = m_tvalid & m_tready;
    // A pop in the same cycle frees the head slot, so a full buffer still accepts.
    assign w_push   = send_in & (~w_full | w_pop);

    // Outputs are gated by valid so the stream reads as zero while empty.
    assign w_head   = mem_q[rd_ptr_q];
    assign m_tdata  = m_tvalid ? w_head[FLIT_WIDTH-1:0] : '0;
    assign m_tdest  = m_tvalid ? w_head[FLIT_WIDTH +: TDEST_WIDTH] : '0;
    assign m_tid    = m_tvalid ? w_head[FLIT_WIDTH+TDEST_WIDTH +: TID_WIDTH] : '0;
    assign m_tlast  = m_tvalid & w_head[c_ENT_W-1];

    assign credit_out      = credit_q;
    assign occupancy       = occ_q;
    assign err_overflow    = err_ovf_q;
    assign err_dest_change = err_dest_q;

    always_ff @(posedge clk_noc) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= {is_tail_in, dest_in, data_in};
        end
    end

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        occ_d     = occ_q;
        credit_d  = w_pop;
        err_ovf_d = err_ovf_q | (send_in & ~w_push);
        if (w_push) begin
            wr_ptr_d = (wr_ptr_q == c_PTR_LAST) ? '0 : wr_ptr_q + c_PTR_ONE;
        end
        if (w_pop) begin
            rd_ptr_d = (rd_ptr_q == c_PTR_LAST) ? '0 : rd_ptr_q + c_PTR_ONE;
        end
        case ({w_push, w_pop})
            2'b10:   occ_d = occ_q + c_OCC_ONE;
            2'b01:   occ_d = occ_q - c_OCC_ONE;
            default: occ_d = occ_q;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        dest_lat_d = dest_lat_q;
        err_dest_d = err_dest_q;
        if (w_push) begin
            case (state_q)
                IDLE: begin
                    if (!is_tail_in) begin
                        state_d    = IN_PKT;
                        dest_lat_d = dest_in;
                    end
                end
                IN_PKT: begin
                    if (dest_in != dest_lat_q) begin
                        err_dest_d = 1'b1;
                    end
                    if (is_tail_in) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_noc or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            occ_q      <= '0;
            credit_q   <= 1'b0;
            err_ovf_q  <= 1'b0;
            err_dest_q <= 1'b0;
            state_q    <= IDLE;
            dest_lat_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            occ_q      <= occ_d;
            credit_q   <= credit_d;
            err_ovf_q  <= err_ovf_d;
            err_dest_q <= err_dest_d;
            state_q    <= state_d;
            dest_lat_q <= dest_lat_d;
        end
    end

`ifdef NOC_LINK_RX_STATS_EN
    logic [31:0]        pkt_cnt_q, pkt_cnt_d;
    logic [31:0]        flit_cnt_q, flit_cnt_d;
    logic [c_OCC_W-1:0] peak_q, peak_d;

    always_comb begin
        pkt_cnt_d  = pkt_cnt_q;
        flit_cnt_d = flit_cnt_q;
        peak_d     = (occ_q > peak_q) ? occ_q : peak_q;
        if (w_pop) begin
            flit_cnt_d = flit_cnt_q + 32'd1;
            if (m_tlast) begin
                pkt_cnt_d = pkt_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk_noc or negedge rst_n) begin
        if (!rst_n) begin
            pkt_cnt_q  <= '0;
            flit_cnt_q <= '0;
            peak_q     <= '0;
        end else begin
            pkt_cnt_q  <= pkt_cnt_d;
            flit_cnt_q <= flit_cnt_d;
            peak_q     <= peak_d;
        end
    end

    assign pkt_count      = pkt_cnt_q;
    assign flit_count     = flit_cnt_q;
    assign peak_occupancy = peak_q;
`endif

endmodule
`default_nettype wire

// File: doc/noc_link_rx_buffer.md
Name: noc_link_rx_buffer

Overview:
- Receive end of a router-to-router credit link. Accepts flits driven by a router output port (data/dest/is_tail/send), buffers them, and returns one credit per dequeued flit.
- Presents buffered flits to a local consumer as an AXI-Stream-style valid/ready stream, splitting dest into tid/tdest.
- Sits at mesh edges, and in front of any endpoint logic that terminates a router output port directly without the deserializer shim.

Parameters:
- FLIT_WIDTH, 64, flit payload width.
- TID_WIDTH, 2, upper field of dest.
- TDEST_WIDTH, 4, lower field of dest.
- DEST_WIDTH, TDEST_WIDTH+TID_WIDTH, dest bus width.
- FLIT_BUFFER_DEPTH, 2, buffer entries; must equal the sender's initial credit count; legal range 1..64.

Ports:
- clk_noc  in  1  single clock.
- rst_n  in  1  asynchronous, active-low reset.
- data_in  in  FLIT_WIDTH  flit payload from the upstream router.
- dest_in  in  DEST_WIDTH  flit destination, {tid, tdest}.
- is_tail_in  in  1  last flit of a packet.
- send_in  in  1  flit valid, one-cycle qualifier.
- credit_out  out  1  one-cycle pulse returning one credit upstream.
- m_tvalid  out  1  output flit valid.
- m_tready  in  1  consumer ready.
- m_tdata  out  FLIT_WIDTH  output payload.
- m_tlast  out  1  equal to the stored is_tail.
- m_tid  out  TID_WIDTH  dest[DEST_WIDTH-1:TDEST_WIDTH].
- m_tdest  out  TDEST_WIDTH  dest[TDEST_WIDTH-1:0].
- occupancy  out  clog2(FLIT_BUFFER_DEPTH+1)  current buffer fill level.
- err_overflow  out  1  sticky error flag.
- err_dest_change  out  1  sticky error flag.

Behaviour:
- Reset values: all outputs 0, pointers 0, FSM in IDLE.
- Enqueue: when send_in=1 and occupancy<DEPTH, store {data, dest, is_tail} at the write pointer.
  - No backpressure exists on the link; send_in is never refused.
- Overflow: send_in=1 while occupancy==DEPTH.
  - Drop the flit.
  - Set err_overflow (sticky until reset).
  - Leave buffer contents and pointers unchanged.
- Output timing: m_t* are driven combinationally from the head entry.
  - m_tvalid = (occupancy != 0).
  - A flit enqueued in cycle N is visible at m_tvalid in cycle N+1.
  - No fall-through from send_in in the same cycle.
- Dequeue on m_tvalid & m_tready.
  - credit_out is a registered pulse, high in cycle N+1 for a pop in cycle N.
  - Exactly one credit per popped flit; never more than one per cycle.
  - Dropped overflow flits return no credit.
- Simultaneous push and pop:
  - When full: the pop frees a slot in the same cycle, so the push is accepted. This is not an overflow; occupancy stays DEPTH.
  - When empty: the push is stored, and m_tvalid is 0 this cycle.
- Pointers wrap modulo FLIT_BUFFER_DEPTH; non-power-of-2 depths are supported.
- m_t* hold stable while m_tvalid=1 and m_tready=0.
- Packet checker FSM, advancing on accepted pushes only:
  - IDLE → IN_PKT on a non-tail flit; latch its dest.
  - IDLE → IDLE on a tail flit (single-flit packet).
  - IN_PKT → IDLE on a tail flit.
  - In IN_PKT, any accepted flit whose dest differs from the latched dest sets err_dest_change (sticky). The flit is still enqueued.
- Reset mid-operation: the buffer is flushed, any pending credit pulse is discarded, and the FSM returns to IDLE.
  - The upstream sender must be reset in the same reset domain, so credit counts realign.

Optional Feature:
- Macro NOC_LINK_RX_STATS_EN.
- When defined, add output ports:
  - pkt_count (32 bits): increments on each popped flit with m_tlast=1.
  - flit_count (32 bits): increments on each popped flit.
  - peak_occupancy: largest occupancy value seen since reset.
  - Both counters wrap at 2^32 and reset to 0.
- When undefined: these ports and their registers do not exist; all other behaviour is identical.

Test Plan:
- Single flit, DEPTH=2: send_in=1, dest=6'b10_0101, is_tail=1, data=64'hA5 → next cycle m_tvalid=1, m_tid=2'b10, m_tdest=4'b0101, m_tlast=1. With m_tready=1, credit_out pulses exactly once, one cycle after the pop.
- Backpressure: m_tready=0, send 2 flits → occupancy=2 and m_tdata holds the first flit. A third send → err_overflow=1, occupancy stays 2, no credit. Then drain with m_tready=1 → exactly 2 credits and 2 flits, in order.
- Full push+pop: full buffer, pop and push in the same cycle → no error, occupancy=2, the new flit appears third in order, one credit.
- 4-flit packet whose 3rd flit has a different dest → err_dest_change=1 and all 4 flits are delivered. A following single-tail packet raises no new error condition.
- Streaming: DEPTH=3, send_in every cycle with a sender model holding 3 initial credits, and m_tready=1 → full throughput of 1 flit/cycle, no overflow, credits equal flits (checked over 1000 flits).
- Reset asserted with occupancy=2 and a credit pulse pending → outputs 0 immediately, no credit after release. With NOC_LINK_RX_STATS_EN: flit_count/pkt_count match the scoreboard and reset to 0.
